// File: rtl/ram_loader.sv
// ram_loader: bus-master that fills the CPU RAM from a byte stream before
// execution starts. Holds the CPU in clear while loading. For each byte it
// drives the RAM address onto the shared bus with mar_in, then the data byte
// with ram_in.
//
// Optional feature: define LOADER_CHECKSUM_EN to accept one extra checksum
// byte after the final data byte. The session fails the check when
// (sum of data + checksum byte) mod 256 != 0.
//
// Ports:
//   clk          system clock, rising edge
//   clear        asynchronous active-high reset
//   start        begin a load session (honoured in IDLE/DONE only)
//   byte_in      stream data byte
//   byte_valid   byte_in is valid
//   byte_last    byte_in is the final data byte of the session
//   byte_ready   loader accepts a byte this cycle
//   bus_out      shared bus drive, high-impedance when not owned
//   mar_in       ORed into MEMORY_ADDRESS_IN
//   ram_in       ORed into RAM_IN
//   cpu_hold     ORed into the CPU clear
//   busy         session in progress
//   done         session complete, held until next start or clear
//   count        data bytes written this session
//   checksum_err checksum mismatch (0 without the feature)
module ram_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic [7:0]            bus_out,
    output logic                  mar_in,
    output logic                  ram_in,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  checksum_err
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_BYTE  = 3'd1,
        S_DRIVE_ADDR = 3'd2,
        S_DRIVE_DATA = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK      = 3'd4,
`endif
        S_DONE       = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              data_q, data_d;
    logic                    last_q, last_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              sum_q, sum_d;
    logic                    cerr_q, cerr_d;
`endif

    logic [CNT_W-1:0]        count_inc;
    logic                    at_depth;
    logic                    bus_drive_c;
    logic [7:0]              bus_val_c;

    assign count_inc = count_q + CNT_W'(1);
    assign at_depth  = (count_inc == CNT_W'(MEM_DEPTH));

    // State and datapath registers
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        cerr_d  = cerr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    cerr_d  = 1'b0;
`endif
                    state_d = S_WAIT_BYTE;
                end
            end
            S_WAIT_BYTE: begin
                // byte_ready is high in this state, so valid alone is a transfer
                if (byte_valid) begin
                    data_d  = byte_in;
                    last_d  = byte_last;
                    state_d = S_DRIVE_ADDR;
                end
            end
            S_DRIVE_ADDR: begin
                state_d = S_DRIVE_DATA;
            end
            S_DRIVE_DATA: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                count_d = count_inc;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = 8'(sum_q + data_q);
`endif
                // last on the MEM_DEPTH-th byte still ends the session only once
                if (last_q || at_depth) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_WAIT_BYTE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                // Checksum byte is compared only, never written to RAM
                if (byte_valid) begin
                    cerr_d  = (8'(sum_q + byte_in) != 8'd0);
                    state_d = S_DONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode
    always_comb begin
        byte_ready  = 1'b0;
        mar_in      = 1'b0;
        ram_in      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        bus_drive_c = 1'b0;
        bus_val_c   = 8'd0;
        case (state_q)
            S_WAIT_BYTE: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_DRIVE_ADDR: begin
                mar_in      = 1'b1;
                busy        = 1'b1;
                bus_drive_c = 1'b1;
                bus_val_c   = 8'(addr_q);
            end
            S_DRIVE_DATA: begin
                ram_in      = 1'b1;
                busy        = 1'b1;
                bus_drive_c = 1'b1;
                bus_val_c   = data_q;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign cpu_hold = busy;
    assign count    = count_q;
    assign bus_out  = bus_drive_c ? bus_val_c : 8'bzzzzzzzz;

`ifdef LOADER_CHECKSUM_EN
    assign checksum_err = cerr_q;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader. A small CPU-side model latches the
// address on mar_in and writes the RAM on ram_in from the shared bus.
`timescale 1ns/1ps
module tb_ram_loader;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_last;
    logic          byte_ready;
    wire  [7:0]    bus_out;
    logic          mar_in;
    logic          ram_in;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          checksum_err;

    ram_loader #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .bus_out      (bus_out),
        .mar_in       (mar_in),
        .ram_in       (ram_in),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .count        (count),
        .checksum_err (checksum_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // CPU-side model and expected RAM image
    logic [7:0] ram     [16];
    logic [7:0] exp_ram [16];
    logic [3:0] mar;
    always @(posedge clk) begin
        if (mar_in) mar <= bus_out[3:0];
        if (ram_in) ram[mar] <= bus_out;
    end

    // Bus discipline checked every cycle once enabled
    bit mon_en = 0;
    int busy_cycles = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (mar_in && ram_in) begin
                errors++;
                $display("FAIL bus_one_hot: mar_in=%b ram_in=%b, required at most one high", mar_in, ram_in);
            end
            if (!mar_in && !ram_in) begin
                checks++;
                if (bus_out !== 8'bzzzzzzzz) begin
                    errors++;
                    $display("FAIL bus_release: bus_out=%h, required zz", bus_out);
                end
            end
            if (busy) busy_cycles++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int         exp_addr;
    int         exp_cnt;
    logic [7:0] sum;

    task automatic check_ram(input string name);
        for (int i = 0; i < 16; i++) chk(name, ram[i], exp_ram[i]);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = 0;
        exp_cnt  = 0;
        sum      = 8'd0;
        chk("start_busy", busy, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_done_clr", done, 0);
        chk("start_count", count, 0);
        chk("start_cerr", checksum_err, 0);
    endtask

    // Called in WAIT_BYTE; returns one cycle after DRIVE_DATA, valid left high
    task automatic send_byte(input logic [7:0] d, input logic l);
        chk("ready_before", byte_ready, 1);
        byte_in    = d;
        byte_valid = 1'b1;
        byte_last  = l;
        step();
        byte_in   = 8'hA5;
        byte_last = 1'b0;
        chk("addr_mar", mar_in, 1);
        chk("addr_ram", ram_in, 0);
        chk("addr_ready", byte_ready, 0);
        chk("addr_bus", bus_out, exp_addr);
        step();
        chk("data_mar", mar_in, 0);
        chk("data_ram", ram_in, 1);
        chk("data_ready", byte_ready, 0);
        chk("data_bus", bus_out, d);
        step();
        exp_ram[exp_addr] = d;
        exp_addr = (exp_addr + 1) % 16;
        exp_cnt++;
        sum = 8'(sum + d);
    endtask

    // Called one cycle after the final data byte
    task automatic finish_session(input logic [7:0] cks, input bit exp_err);
`ifdef LOADER_CHECKSUM_EN
        chk("check_ready", byte_ready, 1);
        chk("check_busy", busy, 1);
        chk("check_done", done, 0);
        byte_in    = cks;
        byte_valid = 1'b1;
        step();
`endif
        byte_valid = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_hold", cpu_hold, 0);
        chk("end_ready", byte_ready, 0);
        chk("end_count", count, exp_cnt);
        chk("end_cerr", checksum_err, exp_err);
        check_ram("end_ram");
    endtask

    typedef struct {
        bit         new_sess;
        logic [7:0] data;
        bit         last;
        logic [4:0] exp_count;
        bit         ends;
    } vec_t;

    vec_t vecs[$];
    vec_t v;

    initial begin
        // Full load 10..1F
        for (int i = 0; i < 16; i++) begin
            v = '{new_sess: (i == 0), data: 8'(8'h10 + i), last: 1'b0,
                  exp_count: 5'(i + 1), ends: (i == 15)};
            vecs.push_back(v);
        end
        // Early stop after three bytes
        vecs.push_back('{1'b1, 8'h1E, 1'b0, 5'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h2F, 1'b0, 5'd2, 1'b0});
        vecs.push_back('{1'b0, 8'hE0, 1'b1, 5'd3, 1'b1});
        // last on the very first byte
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 5'd1, 1'b1});
        // last coinciding with the MEM_DEPTH-th byte
        for (int i = 0; i < 16; i++) begin
            v = '{new_sess: (i == 0), data: 8'(8'h80 + i), last: (i == 15),
                  exp_count: 5'(i + 1), ends: (i == 15)};
            vecs.push_back(v);
        end

        for (int i = 0; i < 16; i++) begin
            ram[i]     = 8'hEE;
            exp_ram[i] = 8'hEE;
        end
        mar        = 4'd0;
        clear      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;

        // Reset state
        step();
        chk("rst_ready", byte_ready, 0);
        chk("rst_mar", mar_in, 0);
        chk("rst_ram", ram_in, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_cerr", checksum_err, 0);
        clear = 1'b0;
        mon_en = 1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_ready", byte_ready, 0);

        // Table-driven sessions
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].new_sess) begin
                busy_cycles = 0;
                do_start();
            end
            send_byte(vecs[k].data, vecs[k].last);
            chk("vec_count", count, vecs[k].exp_count);
            if (vecs[k].ends) begin
                finish_session(8'(8'd0 - sum), 1'b0);
                if (k == 15) begin
`ifdef LOADER_CHECKSUM_EN
                    chk("full_busy_cycles", busy_cycles, 49);
`else
                    chk("full_busy_cycles", busy_cycles, 48);
`endif
                end
            end else begin
                chk("vec_busy", busy, 1);
                chk("vec_ready", byte_ready, 1);
                chk("vec_done", done, 0);
            end
        end

        // Stall with a start pulse while busy
        do_start();
        send_byte(8'h55, 1'b0);
        byte_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ready", byte_ready, 1);
            chk("stall_mar", mar_in, 0);
            chk("stall_ram", ram_in, 0);
            start = (i == 2);
            step();
        end
        start = 1'b0;
        chk("stall_count", count, 1);
        chk("stall_busy", busy, 1);
        send_byte(8'h66, 1'b1);
        chk("stall_end_count", count, 2);
        finish_session(8'(8'd0 - sum), 1'b0);
        chk("stall_ram0", ram[0], 8'h55);
        chk("stall_ram1", ram[1], 8'h66);

        // Clear in DRIVE_DATA of the fourth byte
        do_start();
        send_byte(8'h91, 1'b0);
        send_byte(8'h92, 1'b0);
        send_byte(8'h93, 1'b0);
        byte_in    = 8'h94;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        step();
        chk("pre_clear_ram_in", ram_in, 1);
        #2 clear = 1'b1;
        #1;
        chk("clr_ready", byte_ready, 0);
        chk("clr_mar", mar_in, 0);
        chk("clr_ram", ram_in, 0);
        chk("clr_hold", cpu_hold, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_count", count, 0);
        chk("clr_cerr", checksum_err, 0);
        checks++;
        if (bus_out !== 8'bzzzzzzzz) begin
            errors++;
            $display("FAIL clr_bus: bus_out=%h, required zz", bus_out);
        end
        step();
        clear = 1'b0;
        step();
        chk("post_clr_busy", busy, 0);
        check_ram("clr_ram_image");
        do_start();
        send_byte(8'h77, 1'b1);
        finish_session(8'(8'd0 - sum), 1'b0);
        chk("reload_ram0", ram[0], 8'h77);
        chk("reload_ram3", ram[3], 8'h83);

`ifdef LOADER_CHECKSUM_EN
        // Explicit checksum pass and fail
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        finish_session(8'hFA, 1'b0);
        chk("cks_ok_count", count, 3);
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        finish_session(8'hFB, 1'b1);
        chk("cks_bad_count", count, 3);
        step();
        chk("cks_err_held", checksum_err, 1);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Bus-master controller that fills the CPU's 16-byte RAM from an external byte stream before execution starts.
- Holds the CPU in clear while loading.
- Sequences the memory address register and RAM write through the existing control lines: MEMORY_ADDRESS_IN, then RAM_IN.
- Drives the shared 8-bit bus only while it owns it, then releases the CPU.

Parameters:
ADDR_WIDTH, 4, RAM address width; the address counter wraps at 2**ADDR_WIDTH.
MEM_DEPTH, 16, number of bytes loaded when `last` is never asserted; must be <= 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clear  input  1  asynchronous, active-high reset.
start  input  1  begin a load session; sampled in IDLE or DONE only.
byte_in  input  8  stream data byte.
byte_valid  input  1  byte_in is valid.
byte_last  input  1  qualifies byte_in as the final data byte of the session.
byte_ready  output  1  loader accepts a byte this cycle.
bus_out  output  8  shared bus drive; 8'bz when not driving.
mar_in  output  1  ORed into the MEMORY_ADDRESS_IN control line.
ram_in  output  1  ORed into the RAM_IN control line.
cpu_hold  output  1  ORed into the CPU clear; high while busy.
busy  output  1  session in progress.
done  output  1  session complete; held until the next start or clear.
count  output  ADDR_WIDTH+1  number of data bytes written this session.
checksum_err  output  1  checksum mismatch; constant 0 without the feature.

Behaviour:
- Clear (async, any state, including mid-write):
  - state=IDLE, address=0, count=0.
  - All outputs 0; bus_out=8'bz.
  - A partially written RAM is not restored.
- States: IDLE, WAIT_BYTE, DRIVE_ADDR, DRIVE_DATA, [CHECK], DONE.
- IDLE / DONE, with start=1:
  - address=0, count=0, done=0, checksum_err=0.
  - Go to WAIT_BYTE; busy=1 and cpu_hold=1 from the next cycle.
- WAIT_BYTE:
  - byte_ready=1.
  - Transfer occurs on a cycle with byte_valid & byte_ready: latch byte_in and byte_last, then go to DRIVE_ADDR.
  - byte_valid=0 stalls indefinitely; no timeout.
- DRIVE_ADDR (1 cycle): bus_out={(8-ADDR_WIDTH)'b0, address}, mar_in=1, byte_ready=0.
- DRIVE_DATA (1 cycle):
  - bus_out=latched byte, ram_in=1.
  - At the end of the cycle: address+1, count+1.
  - If the latched last=1 or count+1==MEM_DEPTH, go to DONE (or CHECK with the feature); otherwise go to WAIT_BYTE.
- Throughput: 3 cycles per byte minimum; byte_ready returns high 2 cycles after a transfer.
- DONE:
  - busy=0, cpu_hold=0, done=1, bus_out=8'bz.
  - count holds the final value.
- Only one of mar_in / ram_in is ever high, and only in a cycle where bus_out is driven.
- start while busy: ignored.
- byte_last on the MEM_DEPTH-th byte: a single termination (no double count).
- byte_last on the first byte: count=1.
- Address counter wraps modulo 2**ADDR_WIDTH; it cannot wrap within one session when MEM_DEPTH <= 2**ADDR_WIDTH.

Optional Feature:
LOADER_CHECKSUM_EN:
- With the macro defined:
  - An 8-bit running sum of the data bytes is accumulated; it is reset on start.
  - After the final data byte, the state CHECK asserts byte_ready for one extra byte, the checksum byte.
  - That byte is not written to RAM.
  - If (sum + checksum byte) mod 256 != 0, checksum_err=1.
  - Go to DONE after the checksum byte is accepted; checksum_err is held with done.
- Without the macro: no CHECK state, checksum_err tied 0, the session ends straight after the final data byte.

Test Plan:
- Full load:
  - Stimulus: start, then 16 bytes 8'h10..8'h1F with valid always high.
  - RAM[0..15]=10..1F; count=16; done=1; cpu_hold=0.
  - Total busy duration 48 cycles.
- Early stop:
  - Stimulus: bytes 8'h1E, 8'h2F, 8'hE0, with last on the third.
  - RAM[0..2] written; RAM[3..15] unchanged; count=3; done=1.
- Stall handling:
  - Stimulus: byte_valid low for 5 cycles between bytes 1 and 2.
  - byte_ready held high throughout; no mar_in/ram_in pulses during the stall; data is correct.
- Mid-session clear:
  - Stimulus: assert clear during DRIVE_DATA of byte 4.
  - All outputs 0 immediately; bus_out=Z.
  - A new start reloads from address 0.
- Bus discipline:
  - Every cycle has at most one of mar_in/ram_in high.
  - bus_out is Z in IDLE, WAIT_BYTE and DONE.
  - A start pulse while busy has no effect on count.
- (LOADER_CHECKSUM_EN) Checksum check:
  - Bytes 01,02,03 with last, then checksum FA → checksum_err=0, count=3.
  - Repeat with checksum FB → checksum_err=1.
